ready_sync_mc: RTL and testbench

Multi-channel successor to the single-channel ready/data synchroniser, in the clk2 (destination) domain. Each of NCH source channels presents a quasi-static data word qualified by a level `ready` from a foreign clock domain. The block synchronises every `ready` through a parametrised flop chain and captures the word on the synchronised rising edge. Captured words are merged through a round-robin arbiter into one valid/ready output stream, with per-channel sticky overflow detection.

---
 rtl/ready_sync_mc.sv | 72 +++++++
 tb/tb_ready_sync_mc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ready_sync_mc.sv
// ready_sync_mc: per-channel ready synchronisers with capture on the synchronised rising edge,
// merged through a round-robin arbiter into a single valid/ready output slot.
module ready_sync_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int NCH = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic                      clk2,
  input  logic                      rstn2,
  input  logic [NCH-1:0]            ready,
  input  logic [NCH*DATA_WIDTH-1:0] data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [CH_W-1:0]           out_ch,
  input  logic                      clear_ovf,
  output logic [NCH-1:0]            overflow
);
  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] prev_q, pend_q, pend_d, ovf_q, ovf_d, cap, gnt, take;
  logic [DATA_WIDTH-1:0] hold_q [NCH];
  logic [CH_W-1:0] rr_q, rr_d, g;
  logic load_en, grant;
  assign cap = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign load_en = ~out_valid | out_ready;
  assign grant = load_en & |pend_q;
  assign gnt = grant ? (NCH'(1) << g) : '0;
  // a grant frees the hold register, so a same-cycle capture on that channel is not an overflow
  assign take = cap & (~pend_q | gnt);
  assign pend_d = (pend_q & ~gnt) | cap;
  assign ovf_d = (clear_ovf ? '0 : ovf_q) | (cap & pend_q & ~gnt);
  assign rr_d = (g == CH_W'(NCH - 1)) ? '0 : g + CH_W'(1);
  assign overflow = ovf_q;
  // scan downward so the pending channel closest above rr_q is the last (winning) assignment
  always_comb begin
    int c;
    c = 0;
    g = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      c = int'(rr_q) + i;
      c = (c >= NCH) ? c - NCH : c;
      g = pend_q[c] ? CH_W'(c) : g;
    end
  end
  always_ff @(posedge clk2 or negedge rstn2) begin
    if (!rstn2) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int k = 0; k < NCH; k++) hold_q[k] <= '0;
      prev_q    <= '0;
      pend_q    <= '0;
      ovf_q     <= '0;
      rr_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      sync_q[0] <= ready;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      for (int k = 0; k < NCH; k++) if (take[k]) hold_q[k] <= data[k*DATA_WIDTH +: DATA_WIDTH];
      if (load_en) out_valid <= |pend_q;
      if (grant) begin
        out_data <= hold_q[g];
        out_ch   <= g;
        rr_q     <= rr_d;
      end
    end
  end
endmodule

// File: tb/tb_ready_sync_mc.sv
// tb_ready_sync_mc: directed stimulus with a cycle model of the capture/arbitration rules,
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_ready_sync_mc;
  localparam int DW = 8;
  localparam int N = 4;
  localparam int S = 2;
  logic clk2 = 1'b0;
  logic rstn2 = 1'b0;
  logic [N-1:0] ready = '0;
  logic [N*DW-1:0] data = '0;
  logic out_ready = 1'b1;
  logic clear_ovf = 1'b0;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic [1:0] out_ch;
  logic [N-1:0] overflow;
  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  ready_sync_mc #(.DATA_WIDTH(DW), .NCH(N), .SYNC_STAGES(S)) dut (
    .clk2(clk2), .rstn2(rstn2), .ready(ready), .data(data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .clear_ovf(clear_ovf), .overflow(overflow)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    else n_pass++;
  endtask

  // model: ready history per edge, pending set, hold words, round-robin search by offset
  logic [N-1:0] m_h [S+1];
  logic [DW-1:0] m_hold [N];
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_ovf = '0;
  int m_rr = 0;
  logic m_v = 1'b0;
  logic [DW-1:0] m_d = '0;
  int m_ch = 0;

  always @(posedge clk2 or negedge rstn2) begin : model
    logic [N-1:0] cap;
    int g;
    bit gr;
    if (!rstn2) begin
      for (int j = 0; j <= S; j++) m_h[j] = '0;
      for (int k = 0; k < N; k++) m_hold[k] = '0;
      m_pend = '0; m_ovf = '0; m_rr = 0; m_v = 1'b0; m_d = '0; m_ch = 0;
    end else begin
      cap = m_h[S-1] & ~m_h[S];
      for (int j = S; j > 0; j--) m_h[j] = m_h[j-1];
      m_h[0] = ready;
      gr = 0;
      g = 0;
      if (!m_v || out_ready) begin
        for (int off = 0; off < N; off++)
          if (!gr && m_pend[(m_rr + off) % N]) begin
            g = (m_rr + off) % N;
            gr = 1;
          end
        m_v = gr;
        if (gr) begin
          m_d = m_hold[g];
          m_ch = g;
          m_rr = (g + 1) % N;
          m_pend[g] = 1'b0;
        end
      end
      if (clear_ovf) m_ovf = '0;
      for (int k = 0; k < N; k++)
        if (cap[k]) begin
          if (m_pend[k]) m_ovf[k] = 1'b1;
          else begin
            m_hold[k] = data[k*DW +: DW];
            m_pend[k] = 1'b1;
          end
        end
    end
  end

  always @(negedge clk2) begin
    #1;
    if (chk_en) begin
      chk("m_valid", 32'(out_valid), 32'(m_v));
      chk("m_data", 32'(out_data), 32'(m_d));
      chk("m_ch", 32'(out_ch), 32'(m_ch));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk2);
  endtask

  task automatic pulse(input int ch, input logic [DW-1:0] d, input int hi, input int lo);
    data[ch*DW +: DW] = d;
    ready[ch] = 1'b1;
    step(hi);
    ready[ch] = 1'b0;
    step(lo);
  endtask

  initial begin
    int cnt;
    step(3);
    rstn2 = 1'b1;
    chk_en = 1;
    step(2);
    // single channel latency
    data[2*DW +: DW] = 8'hA5;
    ready[2] = 1'b1;
    step(3); #1;
    chk("t1_early", 32'(out_valid), 0);
    step(1); #1;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_ch", 32'(out_ch), 2);
    step(1); #1;
    chk("t1_once", 32'(out_valid), 0);
    chk("t1_ovf", 32'(overflow), 0);
    ready[2] = 1'b0;
    step(6);
    // all channels together, pointer at 0 then at 1
    pulse(3, 8'h77, 5, 5);
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    ready = 4'hF;
    step(3);
    for (int i = 0; i < 4; i++) begin
      step(1); #1;
      chk("t2_ch", 32'(out_ch), i);
      chk("t2_data", 32'(out_data), 32'h10 + i);
    end
    step(1); #1;
    chk("t2_idle", 32'(out_valid), 0);
    ready = '0;
    step(6);
    pulse(0, 8'h10, 5, 5);
    ready = 4'hF;
    step(3);
    for (int i = 0; i < 4; i++) begin
      step(1); #1;
      chk("t2b_ch", 32'(out_ch), (1 + i) % 4);
      chk("t2b_data", 32'(out_data), 32'h10 + (1 + i) % 4);
    end
    ready = '0;
    step(6);
    // backpressure
    data = {8'h23, 8'h22, 8'h21, 8'h20};
    ready = 4'hF;
    step(4); #1;
    chk("t3_first", 32'(out_ch), 1);
    out_ready = 1'b0;
    step(10); #1;
    chk("t3_hold_v", 32'(out_valid), 1);
    chk("t3_hold_ch", 32'(out_ch), 1);
    chk("t3_hold_d", 32'(out_data), 32'h21);
    ready = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1); #1;
      chk("t3_drain", 32'(out_data), 32'h20 + (2 + i) % 4);
    end
    step(1); #1;
    chk("t3_idle", 32'(out_valid), 0);
    // overflow
    out_ready = 1'b0;
    pulse(0, 8'h55, 5, 5);
    pulse(1, 8'h33, 5, 5);
    pulse(1, 8'h44, 5, 5);
    #1;
    chk("t4_ovf", 32'(overflow), 32'b0010);
    chk("t4_slot", 32'(out_data), 32'h55);
    out_ready = 1'b1;
    step(1); #1;
    chk("t4_kept", 32'(out_data), 32'h33);
    chk("t4_kept_ch", 32'(out_ch), 1);
    step(1); #1;
    chk("t4_sticky", 32'(overflow), 32'b0010);
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    #1;
    chk("t4_clear", 32'(overflow), 0);
    out_ready = 1'b0;
    pulse(0, 8'h66, 5, 5);
    pulse(1, 8'h77, 5, 5);
    data[DW +: DW] = 8'h88;
    ready[1] = 1'b1;
    step(2);
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    #1;
    chk("t4_set_wins", 32'(overflow), 32'b0010);
    ready[1] = 1'b0;
    step(5);
    out_ready = 1'b1;
    step(1); #1;
    chk("t4_old_word", 32'(out_data), 32'h77);
    step(2);
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    step(1);
    // reset mid-operation
    out_ready = 1'b0;
    data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ready = 4'hF;
    step(5); #1;
    chk("t5_busy", 32'(out_valid), 1);
    #1;
    rstn2 = 1'b0;
    ready = '0;
    #1;
    chk("t5_rst_v", 32'(out_valid), 0);
    chk("t5_rst_d", 32'(out_data), 0);
    chk("t5_rst_ch", 32'(out_ch), 0);
    chk("t5_rst_ovf", 32'(overflow), 0);
    step(2);
    rstn2 = 1'b1;
    step(8); #1;
    chk("t5_no_stale", 32'(out_valid), 0);
    // ready held high across reset release
    out_ready = 1'b1;
    #1;
    rstn2 = 1'b0;
    data[0 +: DW] = 8'hC3;
    ready[0] = 1'b1;
    step(2);
    rstn2 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1); #1;
      if (out_valid) cnt++;
    end
    chk("t6_one_evt", 32'(cnt), 1);
    chk("t6_data", 32'(out_data), 32'hC3);
    ready[0] = 1'b0;
    step(6);
    data[0 +: DW] = 8'hC4;
    ready[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1); #1;
      if (out_valid) cnt++;
    end
    chk("t6_retoggle", 32'(cnt), 1);
    chk("t6_data2", 32'(out_data), 32'hC4);
    ready[0] = 1'b0;
    step(4);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
